// File: rtl/seq_player.sv
// Plays an 8-bit pattern LSB-first on LD, holding each bit STEP_CYCLES clocks,
// then pulses DONE for one cycle. All outputs come straight from flops.
module seq_player #(
  parameter int unsigned STEP_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] SEQ,
  output logic       LD,
  output logic [2:0] STEP,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             ld_q, ld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d  = state_q;
    shadow_d = shadow_q;
    step_d   = step_q;
    tick_d   = tick_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          shadow_d = SEQ;
          step_d   = 3'd0;
          tick_d   = '0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (step_q == 3'd7) begin
            step_d  = 3'd0;
            state_d = FINISH;
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: begin
        state_d = IDLE;
        step_d  = 3'd0;
        tick_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they are
    // aligned with state_q and never glitch or depend combinationally on inputs.
    ld_d   = (state_d == PLAY) && shadow_d[step_d];
    busy_d = (state_d == PLAY);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      shadow_q <= 8'd0;
      step_q   <= 3'd0;
      tick_q   <= '0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      ld_q     <= ld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign LD   = ld_q;
  assign STEP = step_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: expected per-cycle outputs {LD,STEP,BUSY,DONE}
// are queued when playback is requested and compared one per clock.
module tb_seq_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start1;
  logic [7:0] seq4, seq1;
  logic       ld4, ld1, busy4, busy1, done4, done1;
  logic [2:0] step4, step1;

  logic [5:0] q4[$];
  logic [5:0] q1[$];
  bit         mon_on = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  seq_player #(.STEP_CYCLES(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .SEQ(seq4),
    .LD(ld4), .STEP(step4), .BUSY(busy4), .DONE(done4)
  );

  seq_player #(.STEP_CYCLES(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .SEQ(seq1),
    .LD(ld1), .STEP(step1), .BUSY(busy1), .DONE(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs for one playback: 8*sc PLAY cycles, then one FINISH cycle.
  task automatic push_play(input bit to_q1, input logic [7:0] s, input int sc);
    logic [5:0] e;
    for (int i = 0; i < 8 * sc; i++) begin
      e = {s[i / sc], 3'(i / sc), 1'b1, 1'b0};
      if (to_q1) q1.push_back(e); else q4.push_back(e);
    end
    if (to_q1) q1.push_back(6'b000001); else q4.push_back(6'b000001);
  endtask

  // With an empty queue the DUT must sit idle: all outputs zero.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check("dut4_out", {ld4, step4, busy4, done4}, (q4.size() != 0) ? q4.pop_front() : 6'b0);
      check("dut1_out", {ld1, step1, busy1, done1}, (q1.size() != 0) ? q1.pop_front() : 6'b0);
    end
  end

  task automatic pulse4(input logic [7:0] s);
    @(negedge clk);
    seq4   = s;
    start4 = 1'b1;
    push_play(1'b0, s, 4);
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", q4.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    seq4   = 8'hFF;
    seq1   = 8'hFF;
    #3;
    check("rst_outs4", {ld4, step4, busy4, done4}, 6'b0);
    check("rst_outs1", {ld1, step1, busy1, done1}, 6'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    // Basic playback, first START after reset release
    pulse4(8'b1010_0101);
    wait_drain();

    // Input isolation: SEQ changes and START re-pulses during PLAY
    pulse4(8'hFF);
    repeat (2) @(negedge clk);
    seq4 = 8'h00;
    repeat (7) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_drain();

    // START held high: three back-to-back periods of 34 cycles
    @(negedge clk);
    seq4   = 8'h01;
    start4 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_play(1'b0, 8'h01, 4);
      q4.push_back(6'b0);
    end
    repeat (102) @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    wait_drain();

    // Empty pattern still runs full length and pulses DONE
    pulse4(8'h00);
    wait_drain();

    // Minimum step length on the STEP_CYCLES=1 instance
    @(negedge clk);
    seq1   = 8'h80;
    start1 = 1'b1;
    push_play(1'b1, 8'h80, 1);
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    wait_drain();

    // Asynchronous reset in PLAY cycle 13 (LD carries bit 3 = 1 at that point)
    pulse4(8'h3C);
    repeat (12) @(posedge clk);
    #2;
    check("abort_pre_ld", ld4, 1);
    check("abort_pre_busy", busy4, 1);
    rst_n = 1'b0;
    q4.delete();
    #1;
    check("abort_ld", ld4, 0);
    check("abort_busy", busy4, 0);
    check("abort_step", step4, 0);
    check("abort_done", done4, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse4(8'h5A);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
